// File: rtl/arch_defs_pkg.sv
// Shared SAP-2 architecture constants and the program-counter action encoding.
package arch_defs_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int ADDR_WIDTH     = 16;
  localparam int PC_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_INC,
    PC_BRANCH,
    PC_RET,
    PC_CALL,
    PC_JUMP
  } pc_action_t;

endpackage : arch_defs_pkg

// File: rtl/pc_return_stack.sv
// Hardware LIFO of return addresses with occupancy counter and full/empty status.
module pc_return_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         full,
  output logic                         empty
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0]  stack_q [DEPTH];
  logic [ADDR_W-1:0]  stack_d [DEPTH];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;

  assign wr_ptr   = PTR_W'(depth_q);
  assign rd_ptr   = PTR_W'(depth_q - DEPTH_W'(1));
  assign full     = (depth_q == DEPTH_W'(DEPTH));
  assign empty    = (depth_q == '0);
  assign pop_data = stack_q[rd_ptr];
  assign depth    = depth_q;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    stack_d = stack_q;
    depth_d = depth_q;
    if (push && !full) begin
      stack_d[wr_ptr] = push_data;
      depth_d         = depth_q + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // NOTE: entries are only ever read below depth_q, so the array needs no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) depth_q <= '0;
    else       depth_q <= depth_d;
  end

endmodule : pc_return_stack

// File: rtl/program_counter_rs.sv
// SAP-2 program counter: staged jump, call/return stack, byte read-out.
// Optional signed relative branch enabled by defining PC_REL_BRANCH_EN.
module program_counter_rs
  import arch_defs_pkg::*;
#(
  parameter int                     ADDR_W       = ADDR_WIDTH,
  parameter int                     DATA_W       = DATA_WIDTH,
  parameter int                     STACK_DEPTH  = PC_STACK_DEPTH,
  parameter logic [ADDR_W-1:0]      RESET_VECTOR = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               load_low_byte,
  input  logic                               load_high_byte,
  input  logic                               jump,
  input  logic                               call,
  input  logic                               ret,
  input  logic                               branch_rel,
  input  logic                               output_high_byte,
  input  logic                               output_low_byte,
  input  logic                               clear_err,
  input  logic [DATA_W-1:0]                  counter_in,
  output logic [ADDR_W-1:0]                  counter_out,
  output logic [DATA_W-1:0]                  counter_byte_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int HI_W = ADDR_W - DATA_W;

  pc_action_t        action;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] staging_q, staging_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push, pop, stk_full, stk_empty;
  logic [ADDR_W-1:0] pop_data;

`ifdef PC_REL_BRANCH_EN
  logic [ADDR_W-1:0] branch_offset;
  assign branch_offset = {{HI_W{counter_in[DATA_W-1]}}, counter_in};
`else
  logic unused_branch_rel;
  assign unused_branch_rel = branch_rel;
`endif

  always_comb begin
    action = PC_HOLD;
    if      (jump)       action = PC_JUMP;
    else if (call)       action = PC_CALL;
    else if (ret)        action = PC_RET;
`ifdef PC_REL_BRANCH_EN
    else if (branch_rel) action = PC_BRANCH;
`endif
    else if (enable)     action = PC_INC;
  end

  assign push = (action == PC_CALL) && !stk_full;
  assign pop  = (action == PC_RET)  && !stk_empty;

  always_comb begin
    pc_d = pc_q;
    case (action)
      PC_INC:    pc_d = pc_q + ADDR_W'(1);
`ifdef PC_REL_BRANCH_EN
      PC_BRANCH: pc_d = pc_q + branch_offset;
`endif
      PC_RET:    if (!stk_empty) pc_d = pop_data;
      PC_CALL,
      PC_JUMP:   pc_d = staging_q;
      default:   pc_d = pc_q;
    endcase
  end

  // An error event in the same cycle as clear_err leaves the flag set.
  always_comb begin
    overflow_d  = clear_err ? 1'b0 : overflow_q;
    underflow_d = clear_err ? 1'b0 : underflow_q;
    if (action == PC_CALL && stk_full)  overflow_d  = 1'b1;
    if (action == PC_RET  && stk_empty) underflow_d = 1'b1;
  end

  always_comb begin
    staging_d = staging_q;
    if (load_low_byte)  staging_d[DATA_W-1:0]      = counter_in;
    if (load_high_byte) staging_d[ADDR_W-1:DATA_W] = counter_in[HI_W-1:0];
  end

  always_comb begin
    byte_d = byte_q;
    if      (output_high_byte) byte_d = DATA_W'(pc_q[ADDR_W-1:DATA_W]);
    else if (output_low_byte)  byte_d = pc_q[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      staging_q   <= '0;
      byte_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      staging_q   <= staging_d;
      byte_q      <= byte_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  pc_return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_q),
    .pop_data  (pop_data),
    .depth     (stack_depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  assign counter_out      = pc_q;
  assign counter_byte_out = byte_q;
  assign stack_overflow   = overflow_q;
  assign stack_underflow  = underflow_q;

endmodule : program_counter_rs
